dcache_ctrl: RTL and testbench



---
 rtl/dcache_pkg.sv | 25 ++
 rtl/dcache_array.sv | 69 ++++++
 rtl/dcache_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// ----------------------------------------------------------------------------
// dcache_pkg : shared geometry defaults and FSM encoding for the data cache
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dcache_pkg;

  localparam int DEF_INDEX_BITS = 5;
  localparam int DEF_WORD_BITS  = 2;
  localparam int DEF_TAG_BITS   = 8;

  localparam int LINES     = 2**DEF_INDEX_BITS;
  localparam int WORD_LSB  = 1;
  localparam int INDEX_LSB = WORD_LSB + DEF_WORD_BITS;
  localparam int TAG_LSB   = INDEX_LSB + DEF_INDEX_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_RETRY = 2'd3;

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// ----------------------------------------------------------------------------
// dcache_array : tag/valid/dirty/data storage, one write port, whole-line read
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int WORD_BITS  = DEF_WORD_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [INDEX_BITS-1:0]                idx,
  input  logic                                 data_we,
  input  logic [WORD_BITS-1:0]                 data_word,
  input  logic [15:0]                          data_wdata,
  input  logic                                 meta_we,
  input  logic [TAG_BITS-1:0]                  meta_tag,
  input  logic                                 dirty_set,
  output logic                                 rd_valid,
  output logic                                 rd_dirty,
  output logic [TAG_BITS-1:0]                  rd_tag,
  output logic [(2**WORD_BITS)-1:0][15:0]      rd_line
);

  localparam int N_LINES = 2**INDEX_BITS;
  localparam int N_WORDS = 2**WORD_BITS;

  logic [N_LINES-1:0]              r_valid;
  logic [N_LINES-1:0]              r_dirty;
  logic [TAG_BITS-1:0]             r_tag  [N_LINES];
  logic [N_WORDS-1:0][15:0]        r_data [N_LINES];

  // Only the state bits are reset; tags and data are don't-care while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (meta_we) begin
        r_valid[idx] <= 1'b1;
        r_dirty[idx] <= 1'b0;
      end
      if (dirty_set) begin
        r_dirty[idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (meta_we) begin
      r_tag[idx] <= meta_tag;
    end
    if (data_we) begin
      r_data[idx][data_word] <= data_wdata;
    end
  end

  assign rd_valid = r_valid[idx];
  assign rd_dirty = r_dirty[idx];
  assign rd_tag   = r_tag[idx];
  assign rd_line  = r_data[idx];

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_ctrl : direct-mapped write-back/write-allocate data cache controller
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int WORD_BITS  = DEF_WORD_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int N_WORDS = 2**WORD_BITS;
  localparam int IDX_LSB = 1 + WORD_BITS;
  localparam int TG_LSB  = IDX_LSB + INDEX_BITS;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [15:0]           r_addr;
  logic [15:0]           r_data;
  logic                  r_wr;
  logic [WORD_BITS-1:0]  r_cnt;

  logic                  w_req;
  logic                  w_hit;
  logic                  w_capture;
  logic                  w_last_ack;
  logic [15:0]           w_addr;
  logic [WORD_BITS-1:0]  w_word;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;

  logic                  w_data_we;
  logic [WORD_BITS-1:0]  w_data_word;
  logic [15:0]           w_data_wdata;
  logic                  w_meta_we;
  logic                  w_dirty_set;
  logic                  w_rd_valid;
  logic                  w_rd_dirty;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [N_WORDS-1:0][15:0] w_rd_line;

  // Malformed requests are flagged and otherwise behave as if absent.
  assign err   = ~rst & (((Rd | Wr) & Addr[0]) | (Rd & Wr));
  assign w_req = ~rst & (Rd | Wr) & ~err;

  assign w_addr     = (r_state == S_IDLE) ? Addr : r_addr;
  assign w_word     = w_addr[IDX_LSB-1:1];
  assign w_idx      = w_addr[TG_LSB-1:IDX_LSB];
  assign w_tag      = w_addr[15:TG_LSB];
  assign w_hit      = w_rd_valid & (w_rd_tag == w_tag);
  assign w_last_ack = mem_ack & (r_cnt == {WORD_BITS{1'b1}});

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .WORD_BITS  (WORD_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .idx        (w_idx),
    .data_we    (w_data_we),
    .data_word  (w_data_word),
    .data_wdata (w_data_wdata),
    .meta_we    (w_meta_we),
    .meta_tag   (w_tag),
    .dirty_set  (w_dirty_set),
    .rd_valid   (w_rd_valid),
    .rd_dirty   (w_rd_dirty),
    .rd_tag     (w_rd_tag),
    .rd_line    (w_rd_line)
  );

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_data_we    = 1'b0;
    w_data_word  = w_word;
    w_data_wdata = DataIn;
    w_meta_we    = 1'b0;
    w_dirty_set  = 1'b0;
    DataOut      = 16'h0000;
    Done         = 1'b0;
    CacheHit     = 1'b0;
    Stall        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            Done        = 1'b1;
            CacheHit    = 1'b1;
            DataOut     = Rd ? w_rd_line[w_word] : 16'h0000;
            w_data_we   = Wr;
            w_dirty_set = Wr;
          end else begin
            Stall        = 1'b1;
            w_capture    = 1'b1;
            w_next_state = (w_rd_valid & w_rd_dirty) ? S_WB : S_FILL;
          end
        end
      end
      S_WB: begin
        Stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {w_rd_tag, w_idx, r_cnt, 1'b0};
        mem_wdata = w_rd_line[r_cnt];
        if (w_last_ack) begin
          w_next_state = S_FILL;
        end
      end
      S_FILL: begin
        Stall        = 1'b1;
        mem_req      = 1'b1;
        mem_addr     = {w_tag, w_idx, r_cnt, 1'b0};
        w_data_we    = mem_ack;
        w_data_word  = r_cnt;
        w_data_wdata = mem_rdata;
        if (w_last_ack) begin
          w_meta_we    = 1'b1;
          w_next_state = S_RETRY;
        end
      end
      default: begin
        Done         = 1'b1;
        DataOut      = r_wr ? 16'h0000 : w_rd_line[w_word];
        w_data_we    = r_wr;
        w_data_wdata = r_data;
        w_dirty_set  = r_wr;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // The word counter rolls over to zero on the final ack, which is also the state exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 16'h0000;
      r_data  <= 16'h0000;
      r_wr    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_addr <= Addr;
        r_data <= DataIn;
        r_wr   <= Wr;
        r_cnt  <= '0;
      end else if (mem_ack && (r_state == S_WB || r_state == S_FILL)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dcache_ctrl : directed plus randomized check of dcache_ctrl against a model
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
  logic        Rd, Wr, Done, Stall, CacheHit, err, mem_req, mem_we, mem_ack;

  dcache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .Rd        (Rd),
    .Wr        (Wr),
    .DataOut   (DataOut),
    .Done      (Done),
    .Stall     (Stall),
    .CacheHit  (CacheHit),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: backing memory by word, cache lines by index.
  logic [15:0] bmem [0:32767];
  bit          m_valid [32];
  bit          m_dirty [32];
  int          m_tag   [32];
  logic [15:0] m_data  [32][4];

  bit          op_we   [8];
  logic [15:0] op_addr [8];
  logic [15:0] op_data [8];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endtask

  // One access from request to completion; abort_at >= 0 asserts rst when that bus op is due.
  task automatic do_access(input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [15:0] din, input int dly, input int abort_at);
    int word, idx, tag, base, n_ops, ptr, waited, stalls;
    bit hit, done, aborted;
    word = (addr / 2) % 4;
    idx  = (addr / 8) % 32;
    tag  = addr / 256;
    @(negedge clk);
    Rd = rd; Wr = wr; Addr = addr; DataIn = din;
    #1;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (hit) begin
      check("hit_done", Done, 1);
      check("hit_flag", CacheHit, 1);
      check("hit_stall", Stall, 0);
      check("hit_memreq", mem_req, 0);
      if (rd) check("hit_load", DataOut, m_data[idx][word]);
      else begin
        m_data[idx][word] = din;
        m_dirty[idx] = 1;
      end
      @(posedge clk); #1;
      Rd = 0; Wr = 0;
    end else begin
      n_ops = 0;
      if (m_valid[idx] && m_dirty[idx]) begin
        base = m_tag[idx] * 256 + idx * 8;
        for (int k = 0; k < 4; k++) begin
          op_we[n_ops] = 1; op_addr[n_ops] = 16'(base + k * 2); op_data[n_ops] = m_data[idx][k];
          n_ops++;
        end
      end
      base = tag * 256 + idx * 8;
      for (int k = 0; k < 4; k++) begin
        op_we[n_ops] = 0; op_addr[n_ops] = 16'(base + k * 2); op_data[n_ops] = 16'h0;
        n_ops++;
      end
      check("miss_stall", Stall, 1);
      check("miss_done", Done, 0);
      stalls = 1; ptr = 0; waited = 0; done = 0; aborted = 0;
      @(posedge clk); #1;
      Rd = 0; Wr = 0; Addr = 16'($urandom); DataIn = 16'($urandom);
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        mem_rdata = 16'($urandom);
        if (ptr == abort_at) begin
          rst = 1; #1;
          check("rst_memreq", mem_req, 0);
          check("rst_stall", Stall, 0);
          check("rst_done", Done, 0);
          check("rst_dataout", DataOut, 0);
          model_reset();
          done = 1; aborted = 1;
        end else if (Done) begin
          done = 1;
          check("retry_hitflag", CacheHit, 0);
          check("retry_stall", Stall, 0);
          check("retry_memreq", mem_req, 0);
          check("ops_done", ptr, n_ops);
          check("stall_cycles", stalls, 1 + n_ops * (dly + 1));
          m_valid[idx] = 1; m_dirty[idx] = wr; m_tag[idx] = tag;
          for (int k = 0; k < 4; k++) m_data[idx][k] = bmem[(base + k * 2) / 2];
          if (rd) check("miss_load", DataOut, m_data[idx][word]);
          else m_data[idx][word] = din;
        end else begin
          stalls++;
          check("busy_stall", Stall, 1);
          if (ptr < n_ops) begin
            check("busy_req", mem_req, 1);
            check("bus_we", mem_we, op_we[ptr]);
            check("bus_addr", mem_addr, op_addr[ptr]);
            if (op_we[ptr]) check("bus_wdata", mem_wdata, op_data[ptr]);
            if (waited == dly) begin
              mem_ack = 1;
              if (op_we[ptr]) bmem[op_addr[ptr] / 2] = op_data[ptr];
              else mem_rdata = bmem[op_addr[ptr] / 2];
              ptr++;
              waited = 0;
            end else begin
              waited++;
            end
          end else begin
            check("extra_req", mem_req, 0);
          end
        end
        @(posedge clk); #1;
        mem_ack = 0;
      end
      if (aborted) rst = 0;
      if (!done) check("timeout", 0, 1);
    end
  endtask

  task automatic err_case(input bit rd, input bit wr, input logic [15:0] addr);
    @(negedge clk);
    Rd = rd; Wr = wr; Addr = addr; DataIn = 16'($urandom);
    #1;
    check("err_flag", err, 1);
    check("err_done", Done, 0);
    check("err_stall", Stall, 0);
    check("err_memreq", mem_req, 0);
    @(posedge clk); #1;
    Rd = 0; Wr = 0;
  endtask

  initial begin
    int sel, dly;
    logic [15:0] a;
    rst = 1; Rd = 0; Wr = 0; Addr = 0; DataIn = 0; mem_ack = 0; mem_rdata = 0;
    for (int i = 0; i < 32768; i++) bmem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) bmem[8 + i] = 16'hA000 + 16'(i);
    for (int i = 0; i < 32; i++) m_tag[i] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("reset_done", Done, 0);
    check("reset_stall", Stall, 0);
    check("reset_hit", CacheHit, 0);
    check("reset_err", err, 0);
    check("reset_memreq", mem_req, 0);
    check("reset_dataout", DataOut, 0);

    do_access(1, 0, 16'h0010, 16'h0, 0, -1);     // cold load, expect 0xA000
    do_access(1, 0, 16'h0010, 16'h0, 0, -1);     // same load hits
    do_access(0, 1, 16'h0012, 16'h1234, 0, -1);  // store hit
    do_access(1, 0, 16'h0012, 16'h0, 0, -1);
    do_access(1, 0, 16'h0110, 16'h0, 0, -1);     // conflict: write back then fill
    do_access(0, 1, 16'h2004, 16'hBEEF, 3, -1);  // store miss with slow memory
    do_access(1, 0, 16'h0004, 16'h0, 1, -1);     // evicts the dirty 0x2004 line
    err_case(1, 0, 16'h0003);
    err_case(1, 1, 16'h0010);
    do_access(1, 0, 16'h0110, 16'h0, 0, -1);     // still resident after the err cycles
    do_access(1, 0, 16'h0518, 16'h0, 0, 1);      // reset during second fill word
    do_access(1, 0, 16'h0518, 16'h0, 0, -1);
    do_access(1, 0, 16'h0110, 16'h0, 0, -1);

    for (int n = 0; n < 300; n++) begin
      a   = 16'(($urandom % 4) * 256 + ($urandom % 4) * 8 + ($urandom % 4) * 2);
      sel = $urandom % 8;
      dly = $urandom % 3;
      if (sel == 0) begin
        if ($urandom % 2) err_case(1'($urandom % 2), 1, a | 16'h1);
        else err_case(1, 1, a);
      end else if (sel < 4) begin
        do_access(1, 0, a, 16'h0, dly, -1);
      end else begin
        do_access(0, 1, a, 16'($urandom), dly, -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
